// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC register and instruction memory and
// buffers returning instructions in a 2-entry FIFO for decode. Redirect
// flushes all buffered and in-flight work.
module fetch_stage #(
  parameter int AW = 8,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_en,
  output logic [AW-1:0] next_pc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_target,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready
);

  // FIFO storage and bookkeeping
  logic [IW-1:0] r_inst_q [2];
  logic [AW-1:0] r_pc_q   [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;

  // Read issued last cycle, and the address it was issued for
  logic          r_inflight;
  logic [AW-1:0] r_tag;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [2:0]    w_level;

  // Handshake, credit check and PC / memory drive
  always_comb begin
    inst_valid = (r_count != 2'd0);
    inst       = r_inst_q[r_rd_ptr];
    inst_pc    = r_pc_q[r_rd_ptr];
    w_pop      = inst_valid & inst_ready;
    // Entries that will be occupied after this edge, counting the read
    // still in flight; a new read is only issued if it is sure to fit.
    w_level    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue    = !reset && !redirect && (w_level < 3'd2);
    // Returning data belongs to a stale path when redirect is high
    w_push     = r_inflight & !redirect;
    imem_rd    = w_issue;
    imem_addr  = pc_addr;
    pc_en      = !reset && (w_issue || redirect);
    next_pc    = redirect ? redirect_target : pc_addr + AW'(1);
  end

  // FIFO: push returning data, pop on accept, flush on redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst_q[0] <= '0;
      r_inst_q[1] <= '0;
      r_pc_q[0]   <= '0;
      r_pc_q[1]   <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else if (redirect) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_inst_q[r_wr_ptr] <= imem_data;
        r_pc_q[r_wr_ptr]   <= r_tag;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // In-flight flag and address tag of the outstanding read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag <= pc_addr;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: models the PC register and a 1-cycle instruction
// memory, keeps the expected instruction stream in a scoreboard queue and
// checks every accepted instruction against it from a separate monitor.
module tb_fetch_stage;
  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc_addr;
  logic          pc_en;
  logic [AW-1:0] next_pc;
  logic          redirect;
  logic [AW-1:0] redirect_target;
  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;

  fetch_stage #(.AW(AW), .IW(IW)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_en(pc_en),
    .next_pc(next_pc), .redirect(redirect), .redirect_target(redirect_target),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_f(input logic [AW-1:0] a);
    return {a ^ 8'h5A, ~a, 8'hC3, a};
  endfunction

  // PC register and synchronous instruction memory around the stage
  always @(posedge clk or posedge reset)
    if (reset) pc_addr <= '0;
    else if (pc_en) pc_addr <= next_pc;

  always @(posedge clk)
    if (imem_rd) imem_data <= mem_f(imem_addr);

  int n_checks = 0;
  int n_err = 0;
  int n_pops = 0;
  int outst = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected stream: sequential addresses from the last reset / redirect
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] gen_pc;
  logic [AW-1:0] sb_e;

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + AW'(1);
    end
  endtask

  task automatic restart(input logic [AW-1:0] a);
    exp_q.delete();
    gen_pc = a;
    refill();
  endtask

  // Monitor: compare each accepted instruction, track buffered + in-flight work
  always @(negedge clk) begin
    if (reset) outst = 0;
    else begin
      if (inst_valid && inst_ready && !redirect) begin
        n_pops++;
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          sb_e = exp_q.pop_front();
          chk("sb_pc", inst_pc, sb_e);
          chk("sb_inst", inst, mem_f(sb_e));
        end
      end
      if (redirect) outst = 0;
      else outst = outst + int'(imem_rd) - int'(inst_valid && inst_ready);
      chk("no_overflow", outst <= 2, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic do_redirect(input logic [AW-1:0] t);
    redirect = 1'b1;
    redirect_target = t;
    tick();
    redirect = 1'b0;
    restart(t);
  endtask

  task automatic wait_valid(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inst_valid) begin ok = 1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  int rd_cnt;
  int seen;
  logic [AW-1:0] seq [3];
  int r;

  initial begin
    redirect = 1'b0;
    redirect_target = '0;
    inst_ready = 1'b0;
    restart(0);
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_pc_en", pc_en, 0);
    repeat (3) tick();

    // Fill latency and one-per-cycle streaming
    inst_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("c0_imem_rd", imem_rd, 1);
    chk("c0_imem_addr", imem_addr, 0);
    tick(); tick();
    @(negedge clk);
    chk("c2_valid", inst_valid, 1);
    chk("c2_inst_pc", inst_pc, 0);
    chk("c2_inst", inst, mem_f(0));
    for (int k = 1; k < 7; k++) begin
      tick();
      @(negedge clk);
      chk("stream_valid", inst_valid, 1);
      chk("stream_pc", inst_pc, AW'(k));
    end

    // Redirect with a simultaneous pop at occupancy 1
    tick();
    do_redirect(8'h20);
    @(negedge clk);
    chk("rp_valid", inst_valid, 0);
    chk("rp_pc", pc_addr, 8'h20);
    chk("rp_imem_addr", imem_addr, 8'h20);

    // Back-pressure: exactly two reads then stall
    tick();
    inst_ready = 1'b0;
    reset = 1'b1;
    restart(0);
    tick();
    reset = 1'b0;
    rd_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (imem_rd) rd_cnt++;
      tick();
    end
    chk("bp_reads", rd_cnt, 2);
    @(negedge clk);
    chk("bp_imem_rd", imem_rd, 0);
    chk("bp_pc_en", pc_en, 0);
    chk("bp_valid", inst_valid, 1);
    chk("bp_inst", inst, mem_f(0));
    tick();
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_no_gap", inst_valid, 1);
      tick();
    end

    // Redirect with one buffered entry and a read in flight
    reset = 1'b1;
    restart(0);
    tick();
    reset = 1'b0;
    tick(); tick();
    do_redirect(8'h40);
    @(negedge clk);
    chk("rd_valid", inst_valid, 0);
    chk("rd_pc", pc_addr, 8'h40);
    wait_valid("rd_first");
    chk("rd_first_pc", inst_pc, 8'h40);

    // Full FIFO then redirect near the top of the address space
    tick();
    inst_ready = 1'b0;
    repeat (4) tick();
    inst_ready = 1'b1;
    do_redirect(8'hFE);
    seen = 0;
    rd_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pc_addr == 8'hFF && imem_rd && seen == 0) begin
        chk("wrap_next_pc", next_pc, 8'h00);
        seen = 1;
      end
      if (inst_valid && rd_cnt < 3) begin
        seq[rd_cnt] = inst_pc;
        rd_cnt++;
      end
      tick();
    end
    chk("wrap_seen", seen, 1);
    chk("wrap_cnt", rd_cnt, 3);
    chk("wrap_pc0", seq[0], 8'hFE);
    chk("wrap_pc1", seq[1], 8'hFF);
    chk("wrap_pc2", seq[2], 8'h00);

    // Reset in the cycle after a read was issued
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_rd) break;
    end
    tick();
    reset = 1'b1;
    #1;
    chk("mr_valid", inst_valid, 0);
    chk("mr_inst", inst, 0);
    chk("mr_inst_pc", inst_pc, 0);
    chk("mr_imem_rd", imem_rd, 0);
    chk("mr_pc_en", pc_en, 0);
    restart(0);
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_first_rd", imem_rd, 1);
    chk("mr_first_addr", imem_addr, 0);
    wait_valid("mr_first");
    chk("mr_first_pc", inst_pc, 0);
    chk("mr_first_inst", inst, mem_f(0));

    // Randomized traffic: back-pressure, redirects, occasional resets
    tick();
    n_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 4) do_redirect(AW'($urandom));
      else if (r == 4) begin
        reset = 1'b1;
        restart(0);
        tick();
        reset = 1'b0;
      end else tick();
    end
    chk("rand_progress", n_pops > 1000, 1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
